// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 9:1 operand-mux arbiter.
// Build option: ARB_BURST_EN enables lock-based multi-beat grants.
package arb_pkg;

  localparam int N_REQ     = 9;
  localparam int SEL_W     = 4;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  // Select code that parks the shared mux on its zero input.
  localparam logic [SEL_W-1:0] IDLE_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: the first set request strictly
// after the pointer wins, wrapping from N_REQ-1 back to 0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);

  int j;

  // Walk from farthest to nearest so the nearest set request is written last.
  always_comb begin
    win    = '0;
    onehot = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (j < N_REQ && req[j]) begin
        win = SEL_W'(j);
        any = 1'b1;
      end
    end
    if (any) onehot[win] = 1'b1;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for the shared 9:1 16-bit operand mux.
// Build option: ARB_BURST_EN adds the lock port and multi-beat grants.
//
// Handshake: out_data is offered while out_valid is high; a beat is accepted
// in any cycle where out_valid && out_ready, and ack pulses to the owner in
// that same cycle. out_valid never drops and out_data never changes before
// acceptance.
module mux_arbiter
  import arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
`ifdef ARB_BURST_EN
  input  logic [N_REQ-1:0]  lock,
`endif
  input  logic [DATA_W-1:0] mux_out,
  output logic [SEL_W-1:0]  mux_sel,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  r_win;
  logic [SEL_W-1:0]  r_sel;
  logic [N_REQ-1:0]  r_grant;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;

  logic [SEL_W-1:0]  w_win;
  logic [N_REQ-1:0]  w_onehot;
  logic              w_any;
  logic              w_hs;
  logic              w_more;

  rr_pick u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .win    (w_win),
    .onehot (w_onehot),
    .any    (w_any)
  );

  // r_valid is only ever high in XFER, so it alone qualifies the handshake.
  assign w_hs = r_valid & out_ready;

`ifdef ARB_BURST_EN
  logic [2:0] r_beats;

  // r_beats counts beats already completed in this grant, excluding the current one.
  assign w_more = req[r_win] & lock[r_win] & (r_beats < 3'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beats <= '0;
    end else if (r_state == IDLE) begin
      r_beats <= '0;
    end else if (w_hs) begin
      r_beats <= r_beats + 3'd1;
    end
  end
`else
  assign w_more = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= SEL_W'(N_REQ - 1);
      r_win   <= '0;
      r_sel   <= IDLE_SEL;
      r_grant <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= SEL;
            r_win   <= w_win;
            r_sel   <= w_win;
            r_grant <= w_onehot;
            r_busy  <= 1'b1;
          end
        end
        SEL: begin
          r_data  <= mux_out;
          r_valid <= 1'b1;
          r_state <= XFER;
        end
        XFER: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_more) begin
              r_state <= SEL;
            end else begin
              r_state <= IDLE;
              r_ptr   <= r_win;
              r_sel   <= IDLE_SEL;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= IDLE_SEL;
          r_grant <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mux_sel   = r_sel;
  assign grant     = r_grant;
  assign ack       = r_grant & {N_REQ{w_hs}};
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule
